// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 radix-2 steps + sign fix); MTHI/MTLO take one.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hilo_read,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t              state, state_next;
  logic [5:0]          counter;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd_b;
  logic [XLEN-1:0]     raw_a;
  logic                is_div, neg_q, neg_r, div_zero;

  logic                accept, accept_md;
  logic                signed_op, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [2*XLEN:0]     div_shift;
  logic [XLEN:0]       div_trial;
  logic [2*XLEN-1:0]   div_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;
  logic [XLEN-1:0]     commit_hi, commit_lo;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_read);

  assign accept    = (state == IDLE) && start && !flush;
  assign accept_md = accept && !op[2];

  // MULT and DIV (even opcodes) are the signed variants
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & src_a[XLEN-1];
  assign b_neg     = signed_op & src_b[XLEN-1];
  assign a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
  assign b_mag     = b_neg ? (~src_b + 1'b1) : src_b;

  // acc low half holds the multiplier being shifted out; high half accumulates
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_b};
  assign mul_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  // restoring division: remainder in the high half, dividend/quotient in the low half
  assign div_shift = {acc, 1'b0};
  assign div_trial = div_shift[2*XLEN:XLEN] - {1'b0, opnd_b};
  assign div_step  = div_trial[XLEN] ? div_shift[2*XLEN-1:0]
                                     : {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};

  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quot_fix = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

  always_comb begin
    commit_hi = prod_fix[2*XLEN-1:XLEN];
    commit_lo = prod_fix[XLEN-1:0];
    if (is_div) begin
      commit_hi = div_zero ? raw_a : rem_fix;
      commit_lo = div_zero ? '1 : quot_fix;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_md) state_next = RUN;
      RUN: begin
        if (flush) state_next = IDLE;
        else if (counter == 6'(XLEN-1)) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && op == OP_MTHI) hi <= src_a;
            if (accept && op == OP_MTLO) lo <= src_a;
            if (accept_md) begin
              counter  <= '0;
              is_div   <= op[1];
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (src_b == '0);
              raw_a    <= src_a;
              acc      <= op[1] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
              opnd_b   <= op[1] ? b_mag : a_mag;
            end
          end
          RUN: begin
            acc     <= is_div ? div_step : mul_step;
            counter <= counter + 6'd1;
          end
          FIX: begin
            hi   <= commit_hi;
            lo   <= commit_lo;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the forwarded ALU operands (ALUIn_forw for rs and rt) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU in 33 cycles and MTHI/MTLO in one cycle.
- Asserts a stall to the hazard/pipeline-control logic while a later MFHI/MFLO or muldiv instruction must wait.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort from exception/branch flush logic
- start  in  1  EX-stage instruction is a muldiv or MTHI/MTLO op
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (treated as no-op)
- src_a  in  XLEN  forwarded rs value
- src_b  in  XLEN  forwarded rt value
- hilo_read  in  1  EX-stage instruction is MFHI/MFLO
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse after HI/LO commit of a mul/div
- stall  out  1  freeze IF/ID/EX, insert bubble into MEM
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, FIX.
- busy=1 in RUN and FIX; done registered.
- stall = busy & (start | hilo_read), combinational.
- Accept:
  - In IDLE with start=1 and flush=0, the op is accepted at that edge (edge E).
  - MTHI: hi<=src_a at E; stays IDLE.
  - MTLO: lo<=src_a at E; stays IDLE.
  - Reserved op: nothing happens.
  - MULT/MULTU/DIV/DIVU: latch operands at E; signed ops convert to magnitudes and record result signs; state<=RUN, counter<=0.
- RUN:
  - One radix-2 iteration per edge; counter increments.
  - Multiply: shift-add over a 64-bit product.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and remainder.
  - After 32 RUN edges (E+32) state<=FIX.
- FIX, at edge E+33:
  - Apply sign correction.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient negative iff signs differ; remainder takes the sign of the dividend.
  - hi<=product[63:32] or remainder; lo<=product[31:0] or quotient.
  - state<=IDLE; done=1 for the cycle after E+33.
- Latency: busy high from E+1 through the edge at E+33 (33 cycles).
- hi/lo change only at the commit edge, at an MTHI/MTLO edge, or on reset.
- Divide by zero (any signedness): lo=32'hFFFFFFFF, hi=src_a unmodified. Still 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: not accepted.
  - stall=1 holds the instruction in EX.
  - It is accepted on the first IDLE edge (the commit edge returns to IDLE; acceptance happens the following edge).
  - Back-to-back ops therefore issue 34 cycles apart.
- hilo_read while busy: stall=1 until IDLE. The MFHI/MFLO then sees the committed hi/lo combinationally.
- hilo_read in IDLE: no stall. An MTHI/MTLO being accepted at that edge is visible next cycle.
- flush:
  - Synchronous, priority over all non-reset events.
  - RUN/FIX go to IDLE; hi/lo unchanged; done not asserted; start in the same cycle is dropped.
  - A flush at the commit edge (FIX) also suppresses the commit.
- Reset mid-operation: immediate return to IDLE with hi/lo=0. No partial results.
- Operand inputs are ignored except at the accept edge; forwarding changes after E have no effect.

Test Plan:
1. Reset, then MULT src_a=0xFFFFFFFE (-2), src_b=3 → busy 33 cycles, done pulse one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
3. Edge cases:
   - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
   - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. Hazard stalls:
   - MULT then MFLO in the next cycle: stall=1 for exactly the busy window, then lo visible with stall=0.
   - A second MULT held with start=1: accepted one edge after commit.
5. Flush:
   - Flush at RUN counter=10 → IDLE next cycle, hi/lo keep their prior values (MTHI 0x1234 loaded earlier stays), no done.
   - Flush in FIX → no commit.
6. Async reset asserted mid-RUN between clock edges → busy, hi, lo = 0 immediately. MTLO 0xA5A5A5A5 after release → lo=0xA5A5A5A5 next cycle, busy never asserts.
